// File: rtl/spi_target_core.sv
// rtl/spi_target_core.sv - single-lane SPI target core with valid/ready RX and TX byte streams
//
// Purpose: oversamples sck/csb/sdi in the clk_i domain. MOSI is deserialised MSB first
//   onto a valid/ready RX stream. Bytes from a valid/ready TX stream are serialised onto
//   MISO. All four CPOL/CPHA modes are supported; the mode is latched at each csb fall.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cpol_i, cpha_i          SPI mode, latched when csb asserts
//   sck_i, csb_i, sdi_i     asynchronous SPI inputs from the host
//   sdo_o, sdo_en_o         MISO data and its output enable
//   tx_data_i/tx_valid_i    next byte to send; tx_ready_o pulses when it is consumed
//   rx_data_o/rx_valid_o    received byte, held until rx_ready_i
//   rx_overflow_o           pulse: byte dropped because rx_valid_o was still pending
//   tx_underflow_o          pulse: load point reached with no TX byte, IdleByte sent
//   active_o                transfer in progress (synchronised csb asserted)
module spi_target_core #(
  parameter int          SyncStages = 2,
  parameter logic [7:0]  IdleByte   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       sck_i,
  input  logic       csb_i,
  input  logic       sdi_i,
  output logic       sdo_o,
  output logic       sdo_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overflow_o,
  output logic       tx_underflow_o,
  output logic       active_o
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                state_q, state_d;
  logic [SyncStages-1:0] sck_sync_q, csb_sync_q, sdi_sync_q;
  logic                  sck_prev_q, csb_prev_q;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            rx_shreg_q, rx_shreg_d;
  logic [7:0]            tx_shreg_q, tx_shreg_d;
  logic                  complete_q, complete_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_overflow_q, rx_overflow_d;

  logic sck_s, csb_s, sdi_s;
  logic sck_rise, sck_fall, csb_fall, csb_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic load;

  assign sck_s = sck_sync_q[SyncStages-1];
  assign csb_s = csb_sync_q[SyncStages-1];
  assign sdi_s = sdi_sync_q[SyncStages-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csb_fall = ~csb_s & csb_prev_q;
  assign csb_rise = csb_s & ~csb_prev_q;

  // Edge roles come from the mode latched at csb fall, not the live inputs.
  assign lead_edge   = cpol_q ? sck_fall : sck_rise;
  assign trail_edge  = cpol_q ? sck_rise : sck_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

  // csb resets deasserted so a held-low csb after reset is seen as a fresh fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q <= '0;
      csb_sync_q <= '1;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SyncStages-2:0], sck_i};
      csb_sync_q <= {csb_sync_q[SyncStages-2:0], csb_i};
      sdi_sync_q <= {sdi_sync_q[SyncStages-2:0], sdi_i};
      sck_prev_q <= sck_s;
      csb_prev_q <= csb_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      cnt_q         <= 3'd0;
      rx_shreg_q    <= 8'h00;
      tx_shreg_q    <= 8'h00;
      complete_q    <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      cnt_q         <= cnt_d;
      rx_shreg_q    <= rx_shreg_d;
      tx_shreg_q    <= tx_shreg_d;
      complete_q    <= complete_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cpol_d         = cpol_q;
    cpha_d         = cpha_q;
    cnt_d          = cnt_q;
    rx_shreg_d     = rx_shreg_q;
    tx_shreg_d     = tx_shreg_q;
    complete_d     = 1'b0;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    rx_overflow_d  = 1'b0;
    load           = 1'b0;
    tx_ready_o     = 1'b0;
    tx_underflow_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (csb_fall) begin
          state_d = ACTIVE;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          cnt_d   = 3'd0;
          // cpha=0 has no shift edge before the first sample, so preload now.
          load    = ~cpha_i;
        end
      end
      ACTIVE: begin
        // csb rise takes precedence over any sck edge seen in the same cycle.
        if (csb_rise) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (sample_edge) begin
            rx_shreg_d = {rx_shreg_q[6:0], sdi_s};
            cnt_d      = cnt_q + 3'd1;
            complete_d = (cnt_q == 3'd7);
          end
          if (shift_edge) begin
            if (cnt_q != 3'd0) begin
              tx_shreg_d = {tx_shreg_q[6:0], 1'b0};
            end else begin
              load = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (tx_valid_i) begin
        tx_shreg_d = tx_data_i;
        tx_ready_o = 1'b1;
      end else begin
        tx_shreg_d     = IdleByte;
        tx_underflow_o = 1'b1;
      end
    end

    // Accept first, then a completing byte may refill (keeping valid high) or overflow.
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
    if (complete_q) begin
      if (rx_valid_q && !rx_ready_i) begin
        rx_overflow_d = 1'b1;
      end else begin
        rx_data_d  = rx_shreg_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  assign sdo_o         = tx_shreg_q[7];
  assign sdo_en_o      = (state_q == ACTIVE);
  assign active_o      = (state_q == ACTIVE);
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overflow_o = rx_overflow_q;

endmodule
